// File: rtl/butterfly_net_32_seq_if.sv
// Request/response bundle for the iterative 32-bit butterfly network.
// The master drives requests and consumes results. The slave is the network itself.
interface butterfly_net_32_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] cfg0;
    logic [15:0] cfg1;
    logic [15:0] cfg2;
    logic [15:0] cfg3;
    logic [15:0] cfg4;
    logic [31:0] mask_in;
    logic        op_pdep;
    logic [31:0] data_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] data_out;

    modport master (
        output in_valid, cfg0, cfg1, cfg2, cfg3, cfg4, mask_in, op_pdep, data_in, out_ready,
        input  in_ready, out_valid, data_out
    );

    modport slave (
        input  in_valid, cfg0, cfg1, cfg2, cfg3, cfg4, mask_in, op_pdep, data_in, out_ready,
        output in_ready, out_valid, data_out
    );
endinterface

// File: rtl/butterfly_net_32_seq.sv
// Iterative 32-bit butterfly network (pdep side of the bitmanip unit).
// Applies one swap stage per clock, in the order d16, d8, d4, d2, d1, with an optional mask on the result.
module butterfly_net_32_seq #(
    parameter int unsigned NSTAGE = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    butterfly_net_32_seq_if.slave  bus
);

    generate
        if (NSTAGE != 5) begin : g_bad_nstage
            $error("butterfly_net_32_seq: NSTAGE must be 5");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    // Single swap stage at distance d. The switch for pair (j, j+d) uses control bit (j/2d)*d + j%d.
    function automatic logic [31:0] bfly_stage(input logic [31:0] x, input int unsigned d,
                                               input logic [15:0] c);
        logic [31:0] y;
        int unsigned k;
        logic [3:0]  kk;
        logic [4:0]  jj;
        logic [4:0]  pj;
        y = x;
        for (int unsigned j = 0; j < 32; j++) begin
            if ((j & d) == 0) begin
                k  = (j / (2 * d)) * d + (j % d);
                kk = k[3:0];
                jj = j[4:0];
                pj = jj + d[4:0];
                if (c[kk]) begin
                    y[jj] = x[pj];
                    y[pj] = x[jj];
                end
            end
        end
        return y;
    endfunction

    state_e            state_q, state_d;
    logic [2:0]        stg_q, stg_d;
    logic [31:0]       data_q, data_d;
    logic [3:0][15:0]  cfg_q, cfg_d;
    logic [31:0]       mask_q, mask_d;
    logic              pdep_q, pdep_d;
    logic              in_ready;
    logic              out_valid;
    logic              accept;

    always_comb begin
        state_d   = state_q;
        stg_d     = stg_q;
        data_d    = data_q;
        cfg_d     = cfg_q;
        mask_d    = mask_q;
        pdep_d    = pdep_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                accept   = bus.in_valid;
            end
            RUN: begin
                stg_d = stg_q + 3'd1;
                case (stg_q)
                    3'd1: data_d = bfly_stage(data_q, 8, cfg_q[3]);
                    3'd2: data_d = bfly_stage(data_q, 4, cfg_q[2]);
                    3'd3: data_d = bfly_stage(data_q, 2, cfg_q[1]);
                    3'd4: begin
                        data_d  = bfly_stage(data_q, 1, cfg_q[0]);
                        stg_d   = '0;
                        state_d = DONE;
                    end
                    default: begin
                        stg_d   = '0;
                        state_d = IDLE;
                    end
                endcase
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = bus.out_ready;
                if (bus.out_ready) begin
                    accept  = bus.in_valid;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // cfg4 is consumed by stage s0 on the accept edge, so only cfg0..cfg3 are kept for later stages.
        if (accept) begin
            data_d  = bfly_stage(bus.data_in, 16, bus.cfg4);
            cfg_d   = {bus.cfg3, bus.cfg2, bus.cfg1, bus.cfg0};
            mask_d  = bus.mask_in;
            pdep_d  = bus.op_pdep;
            stg_d   = 3'd1;
            state_d = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            stg_q   <= '0;
            data_q  <= '0;
            cfg_q   <= '0;
            mask_q  <= '0;
            pdep_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stg_q   <= stg_d;
            data_q  <= data_d;
            cfg_q   <= cfg_d;
            mask_q  <= mask_d;
            pdep_q  <= pdep_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.data_out  = pdep_q ? (data_q & mask_q) : data_q;

endmodule

// File: tb/tb_butterfly_net_32_seq.sv
// Directed and round-trip checks for butterfly_net_32_seq: latency, hold, reset and pdep masking.
module tb_butterfly_net_32_seq;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;

    butterfly_net_32_seq_if bus ();

    butterfly_net_32_seq #(.NSTAGE(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Pair-oriented model: iterates over switch index k instead of bit position.
    function automatic logic [31:0] m_pairs(input logic [31:0] x, input int unsigned d,
                                            input logic [15:0] c);
        logic [31:0] y;
        int unsigned j;
        logic [4:0]  a;
        logic [4:0]  b;
        logic [3:0]  kk;
        logic        t;
        y = x;
        for (int unsigned k = 0; k < 16; k++) begin
            j  = (k / d) * 2 * d + (k % d);
            a  = j[4:0];
            b  = a + d[4:0];
            kk = k[3:0];
            if (c[kk]) begin
                t    = y[a];
                y[a] = y[b];
                y[b] = t;
            end
        end
        return y;
    endfunction

    function automatic logic [31:0] m_fwd(input logic [31:0] x, input logic [4:0][15:0] c);
        logic [31:0] y;
        y = m_pairs(x, 16, c[4]);
        y = m_pairs(y, 8, c[3]);
        y = m_pairs(y, 4, c[2]);
        y = m_pairs(y, 2, c[1]);
        return m_pairs(y, 1, c[0]);
    endfunction

    function automatic logic [31:0] m_inv(input logic [31:0] x, input logic [4:0][15:0] c);
        logic [31:0] y;
        y = m_pairs(x, 1, c[0]);
        y = m_pairs(y, 2, c[1]);
        y = m_pairs(y, 4, c[2]);
        y = m_pairs(y, 8, c[3]);
        return m_pairs(y, 16, c[4]);
    endfunction

    // Called in the low clock phase; returns just after the accept edge.
    task automatic send(input logic [31:0] d, input logic [4:0][15:0] c,
                        input logic [31:0] m, input logic p);
        bus.data_in  = d;
        bus.cfg0     = c[0];
        bus.cfg1     = c[1];
        bus.cfg2     = c[2];
        bus.cfg3     = c[3];
        bus.cfg4     = c[4];
        bus.mask_in  = m;
        bus.op_pdep  = p;
        bus.in_valid = 1'b1;
        #1;
        check("in_ready_at_accept", {31'b0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    // Returns on the negedge where out_valid is first seen; latency counts cycles after acceptance.
    task automatic wait_result(input string tag, input logic [31:0] exp);
        int cyc;
        cyc = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid) break;
            @(posedge clk);
            cyc++;
        end
        check({tag, "_valid"}, {31'b0, bus.out_valid}, 32'd1);
        check({tag, "_latency"}, cyc, 32'd5);
        check({tag, "_data"}, bus.data_out, exp);
    endtask

    task automatic do_op(input string tag, input logic [31:0] d, input logic [4:0][15:0] c,
                         input logic [31:0] m, input logic p, input logic [31:0] exp);
        send(d, c, m, p);
        wait_result(tag, exp);
    endtask

    logic [4:0][15:0] cfg;
    logic [31:0]      x, y, m, held;
    logic             p;
    int               stray;

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.data_in   = '0;
        bus.cfg0      = '0;
        bus.cfg1      = '0;
        bus.cfg2      = '0;
        bus.cfg3      = '0;
        bus.cfg4      = '0;
        bus.mask_in   = '0;
        bus.op_pdep   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        check("rst_data_out", bus.data_out, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        cfg = '0;
        do_op("identity", 32'hDEADBEEF, cfg, 32'h0, 1'b0, 32'hDEADBEEF);
        cfg = {5{16'hFFFF}};
        do_op("reverse", 32'h00000001, cfg, 32'h0, 1'b0, 32'h80000000);
        cfg = {16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0};
        do_op("cfg4_only", 32'h0000FFFF, cfg, 32'h0, 1'b0, 32'hFFFF0000);
        cfg = {16'h0, 16'h0, 16'h0, 16'h0, 16'h0001};
        do_op("cfg0_bit0", 32'h00000001, cfg, 32'h0, 1'b0, 32'h00000002);
        cfg = {16'h0, 16'h0, 16'h0, 16'h0001, 16'h0};
        do_op("cfg1_bit0", 32'h00000001, cfg, 32'h0, 1'b0, 32'h00000004);
        cfg = '0;
        do_op("pdep_mask", 32'hFFFFFFFF, cfg, 32'h0F0F00F0, 1'b1, 32'h0F0F00F0);

        // Backpressure: result must hold for 7 cycles, with no accept despite in_valid.
        @(negedge clk);
        bus.out_ready = 1'b0;
        cfg = '0;
        do_op("hold_first", 32'h12345678, cfg, 32'h0, 1'b0, 32'h12345678);
        held = bus.data_out;
        bus.data_in  = 32'hA5A5A5A5;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_valid", {31'b0, bus.out_valid}, 32'd1);
            check("hold_data", bus.data_out, held);
            check("hold_in_ready", {31'b0, bus.in_ready}, 32'd0);
        end
        bus.out_ready = 1'b1;
        cfg = {5{16'hFFFF}};
        do_op("back_to_back", 32'h00000001, cfg, 32'h0, 1'b0, 32'h80000000);

        // Reset in the middle of a run drops the operation entirely.
        @(negedge clk);
        cfg = '0;
        send(32'hCAFEF00D, cfg, 32'hFFFFFFFF, 1'b1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("midrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("midrst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        check("midrst_data_out", bus.data_out, 32'h0);
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.out_valid) stray++;
        end
        check("midrst_no_stale", stray, 32'd0);

        // Random: even iterations check round-trip through the inverse model, odd ones the forward model.
        for (int i = 0; i < 2000; i++) begin
            x = $urandom;
            m = $urandom;
            p = 1'($urandom_range(0, 1));
            for (int s = 0; s < 5; s++) cfg[s] = 16'($urandom);
            if ((i % 2) == 0) begin
                y = m_inv(x, cfg);
                do_op("rand_roundtrip", y, cfg, m, p, p ? (x & m) : x);
            end else begin
                y = m_fwd(x, cfg);
                do_op("rand_forward", x, cfg, m, p, p ? (y & m) : y);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
